// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: grants one finished functional-unit
// result per unstalled cycle and registers its ROB tag, value and source onto the CDB.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]      req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]     req_val,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          stall,
  input  logic                          flush,
  output logic                          cdb_valid,
  output logic [TAG_W-1:0]              cdb_tag,
  output logic [DATA_W-1:0]             cdb_val,
  output logic [$clog2(NUM_REQ)-1:0]    cdb_src,
  output logic [CNT_W-1:0]              contention_cnt
);

  localparam int SRC_W = $clog2(NUM_REQ);

  logic [TAG_W-1:0]  w_tag       [NUM_REQ];
  logic [DATA_W-1:0] w_val       [NUM_REQ];
  logic [SRC_W-1:0]  w_scan_idx  [NUM_REQ];
  logic              w_grant_found;
  logic [SRC_W-1:0]  w_grant_idx;
  logic              w_grant_en;
  logic              w_multi_req;
  logic [SRC_W-1:0]  w_next_ptr;

  logic              r_cdb_valid;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic [DATA_W-1:0] r_cdb_val;
  logic [SRC_W-1:0]  r_cdb_src;
  logic [SRC_W-1:0]  r_rr_ptr;
  logic [CNT_W-1:0]  r_cnt;

  // Slice the flat request buses and precompute the rotated scan order.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_tag[gi]      = req_tag[gi*TAG_W +: TAG_W];
      assign w_val[gi]      = req_val[gi*DATA_W +: DATA_W];
      assign w_scan_idx[gi] = SRC_W'((int'(r_rr_ptr) + gi) % NUM_REQ);
      assign req_ready[gi]  = w_grant_en && (w_grant_idx == SRC_W'(gi));
    end
  endgenerate

  // Scan from the farthest offset back to rr_ptr so the closest valid requester wins.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[w_scan_idx[k]]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_scan_idx[k];
      end
    end
  end

  assign w_grant_en  = w_grant_found && !stall && !flush && !rst;
  assign w_multi_req = |(req_valid & (req_valid - NUM_REQ'(1)));
  assign w_next_ptr  = (w_grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + SRC_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_val   <= '0;
      r_cdb_src   <= '0;
      r_rr_ptr    <= '0;
    end else if (flush) begin
      r_cdb_valid <= 1'b0;
      r_rr_ptr    <= '0;
    end else if (!stall) begin
      if (w_grant_found) begin
        r_cdb_valid <= 1'b1;
        r_cdb_tag   <= w_tag[w_grant_idx];
        r_cdb_val   <= w_val[w_grant_idx];
        r_cdb_src   <= w_grant_idx;
        r_rr_ptr    <= w_next_ptr;
      end else begin
        r_cdb_valid <= 1'b0;
      end
    end
  end

  // Saturating count of contended grants; flush does not clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_grant_en && w_multi_req && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cdb_valid      = r_cdb_valid;
  assign cdb_tag        = r_cdb_tag;
  assign cdb_val        = r_cdb_val;
  assign cdb_src        = r_cdb_src;
  assign contention_cnt = r_cnt;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin arbiter for the single common data bus (CDB).
- Shares the bus among the functional units that sit behind the reservation stations.
- Each cycle it grants one completed result and registers its ROB tag and value onto the CDB.
- The ROB and all reservation stations snoop the CDB to wake up waiting operands.

Parameters:
NUM_REQ, 4, number of functional-unit requesters (2..8)
TAG_W, 4, ROB tag width; must match INST_TAG_WIDTH
DATA_W, 32, result width; must match COMMON_WIDTH
CNT_W, 16, width of the saturating contention counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  bit i: unit i holds a finished result
req_tag  input  NUM_REQ*TAG_W  slice i: ROB tag of unit i result
req_val  input  NUM_REQ*DATA_W  slice i: result value of unit i
req_ready  output  NUM_REQ  one-hot combinational grant; unit i may drop its result after a rising edge where valid&ready
stall  input  1  CDB consumer cannot accept this cycle
flush  input  1  mispredict/exception flush; kills in-flight broadcast
cdb_valid  output  1  registered; CDB carries a valid broadcast
cdb_tag  output  TAG_W  registered broadcast tag
cdb_val  output  DATA_W  registered broadcast value
cdb_src  output  clog2(NUM_REQ)  registered index of the granted unit
contention_cnt  output  CNT_W  saturating count of cycles with ≥2 req_valid bits and a grant issued

Behaviour:
- Reset (async, rst=1): cdb_valid=0, cdb_tag=0, cdb_val=0, cdb_src=0, contention_cnt=0, rr_ptr=0. req_ready=0 while rst is high.
- State: rr_ptr, clog2(NUM_REQ) bits, is the highest-priority index for the current cycle.
- Grant is combinational from req_valid, rr_ptr, stall, flush:
  - If flush=1 or stall=1: req_ready=0.
  - Otherwise grant g is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ. req_ready is one-hot at g, or all zero if no request.
- Rising edge, priority order flush > stall > grant > idle:
  - flush: cdb_valid←0; rr_ptr←0; cdb_tag/val/src hold; no handshake completes.
  - stall (no flush): all cdb_* and rr_ptr hold their values; a valid broadcast stays on the bus until accepted.
  - grant: cdb_valid←1; cdb_tag/cdb_val←slice g; cdb_src←g; rr_ptr←(g+1) mod NUM_REQ.
  - idle (no request): cdb_valid←0; rr_ptr holds; tag/val/src hold.
- Latency: result presented in cycle N with grant appears on the CDB in cycle N+1. Throughput is one broadcast per unstalled cycle.
- Fairness: any continuously valid requester is granted within NUM_REQ unstalled, unflushed cycles.
- contention_cnt: increments by 1 on a grant edge when popcount(req_valid)≥2. Saturates at 2^CNT_W−1 with no wrap. Unaffected by flush.
- Requester contract (bench checks with assertions; arbiter does not enforce):
  - req_tag/req_val stay stable while req_valid=1 and req_ready=0.
  - req_valid may not drop before the grant unless flush=1.
- Simultaneous flush and request: no grant is issued. Requesters are expected to drop their valid after the flush.
- rst asserted mid-broadcast: outputs clear immediately, without waiting for clk.

Test Plan:
- Reset: rst=1 with req_valid=4'b1111 → req_ready=0, cdb_valid=0, contention_cnt=0. Release rst → first grant to unit 0.
- Round-robin: req_valid=4'b1111 held, tags 1,2,3,4 on units 0-3 → CDB tags 1,2,3,4,1 on consecutive cycles; cdb_src 0,1,2,3,0; contention_cnt=5 after 5 grants.
- Pointer skip: rr_ptr=1, req_valid=4'b1001 → grant unit 3 (tag 7, val 0xDEADBEEF) next cycle. Then with req_valid=4'b0001, grant unit 0. contention_cnt increments only on the first grant.
- Stall hold: broadcast tag 5 val 0x12 on CDB, stall=1 for 3 cycles with req_valid=4'b0100 → CDB holds tag 5/0x12 with cdb_valid=1; req_ready=0. Stall drops → unit 2 granted next edge.
- Flush: grant to unit 1 on CDB, flush=1 with req_valid=4'b0110 → next cycle cdb_valid=0, req_ready=0, rr_ptr=0. Flush drops with req_valid=4'b0100 → unit 2 granted.
- Saturation: CNT_W=2, eight contended grants → contention_cnt reaches 3 and stays 3.
